sram_like_slave: RTL and testbench
==================================

SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter RAM_AW, default 16: word-address width of the backing synchronous RAM.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum accepted-but-unanswered transactions.
REQ-003 SHALL use one clock and a synchronous, active-low reset; all ports are listed below.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port resetn, input, 1: synchronous, active-low reset.
REQ-006 Port req, input, 1: master request; req, wr, wstrb, size, addr and wdata are held stable until addr_ok.
REQ-007 Port wr, input, 1: 1 = write, 0 = read.
REQ-008 Port wstrb, input, 4: byte-lane write enables.
REQ-009 Port size, input, 2: transfer size, 0 = byte, 1 = half, 2 = word.
REQ-010 Port addr, input, 32: byte address.
REQ-011 Port wdata, input, 32: write data.
REQ-012 Port addr_ok, output, 1: request accepted this cycle when req is also 1.
REQ-013 Port data_ok, output, 1: one transaction completed this cycle, in order.
REQ-014 Port rdata, output, 32: read data, valid while data_ok is 1.
REQ-015 Port delay_cfg, input, 4: extra wait cycles before each data_ok.
REQ-016 Port ram_en, output, 1: RAM access enable.
REQ-017 Port ram_we, output, 4: RAM byte write enables.
REQ-018 Port ram_addr, output, RAM_AW: RAM word address, equal to addr[RAM_AW+1:2].
REQ-019 Port ram_wdata, output, 32: RAM write data.
REQ-020 Port ram_rdata, input, 32: RAM read data, valid one cycle after ram_en with ram_we == 0.

Function
REQ-021 addr_ok SHALL equal (out_cnt < MAX_OUT), where out_cnt is a registered count; addr_ok SHALL NOT depend on req or on same-cycle data_ok.
REQ-022 A handshake at cycle T is req & addr_ok.
  - On a handshake, drive ram_en = 1 in T.
  - On a handshake, drive ram_we = wr ? wstrb : 0 in T.
  - On a handshake, drive ram_wdata = wdata in T.
  - With no handshake, ram_en = 0 and ram_we = 0.
REQ-023 Each handshake SHALL latch a pending flag and is_read = ~wr.
  - At T+1, push {is_read, is_read ? ram_rdata : 0} into a MAX_OUT-deep response FIFO.
REQ-024 When an entry becomes FIFO head, a wait counter SHALL load delay_cfg.
  - The counter decrements each cycle while nonzero.
  - A delay_cfg change after the load has no effect on that entry.
REQ-025 data_ok SHALL be a registered output, high exactly one cycle when the head is valid and the counter is 0.
  - rdata = head data in that cycle, else 0.
  - The head pops in the same cycle.
REQ-026 Latency SHALL be: first data_ok at T+2+delay_cfg for an idle slave.
  - Subsequent entries complete at previous data_ok + 1 + delay_cfg.
REQ-027 out_cnt SHALL update as +1 on a handshake, -1 on data_ok, and unchanged when both occur.
  - out_cnt never exceeds MAX_OUT.
  - out_cnt never underflows.
REQ-028 Writes SHALL produce data_ok with rdata = 0.
  - Reads return the full 32-bit word regardless of size; the master extracts the bytes.
REQ-029 Responses SHALL be strictly in acceptance order, and reads and writes SHALL be interleavable.
REQ-030 A read following a write to the same word SHALL return the written data, since the RAM write occurs in the write's handshake cycle.

Reset
REQ-031 While resetn = 0 at a clock edge, the following SHALL clear:
  - out_cnt = 0
  - FIFO empty
  - pending flag = 0
  - wait counter = 0
  - data_ok = 0
  - rdata = 0
REQ-032 During reset, addr_ok SHALL read 1 combinationally from out_cnt = 0, and ram_en = 0 and ram_we = 0 unless req is 1.
REQ-033 Reset mid-operation SHALL discard all outstanding transactions with no data_ok generated for them.
  - Completed RAM writes are not rolled back.

Structure
REQ-034 Shared package sram_like_pkg SHALL hold the following, reused by the core stages:
  - size encodings: SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
  - default MAX_OUT
  - response-entry typedef {is_read, data[31:0]}
REQ-035 The design SHALL contain one sub-module, resp_fifo.
  - resp_fifo is a synchronous MAX_OUT-entry FIFO with push, pop, full, empty, head data and synchronous active-low reset.

Verification
REQ-036 Single read: RAM word 5 = 32'hDEADBEEF, delay_cfg = 0, read addr 32'h14 handshake at T -> ram_en = 1 and ram_addr = 5 at T; data_ok = 1 and rdata = 32'hDEADBEEF at T+2 only.
REQ-037 Write then read: write addr 32'h20, wstrb 4'b0011, wdata 32'h12345678 over old word 32'hAAAAAAAA; then read 32'h20 -> write data_ok rdata = 0; read rdata = 32'hAAAA5678.
REQ-038 Backpressure: req held high, delay_cfg = 3, three reads -> addr_ok drops after 2 handshakes.
  - data_ok at T+5 and T+9.
  - Third handshake in the cycle after the first data_ok.
REQ-039 Simultaneous events: out_cnt = 1 with a handshake and data_ok in the same cycle -> out_cnt stays 1 and addr_ok stays 1.
REQ-040 Delay change: delay_cfg changed 4 -> 0 while the head counts -> that head still completes at T+6; the next entry uses 0.
REQ-041 Reset mid-operation: resetn = 0 for 1 cycle with 2 outstanding -> no data_ok afterward, addr_ok = 1, next read served normally.

Source files
------------

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like slave: size encodings, default depth
// and the response entry carried from the RAM read stage to the bus.
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int DEF_MAX_OUT = 2;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } resp_t;

    function automatic logic size_legal(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
    endfunction

endpackage

// File: rtl/sram_like_slave_resp_fifo.sv
// In-order response queue between the RAM read stage and the data_ok stage.
// Pointers and occupancy are reset; the storage itself is not.
module resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUT
) (
    input  logic  clk,
    input  logic  resetn,
    input  logic  push,
    input  resp_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output resp_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    resp_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_like_slave.sv
// SRAM-like bus slave in front of a synchronous RAM: accepts up to MAX_OUT
// transactions, answers them in order after a programmable wait.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int RAM_AW  = 16,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [3:0]        wstrb,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    input  logic [3:0]        delay_cfg,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = $clog2(MAX_OUT + 1);

    logic [CW-1:0] out_cnt;
    logic          hs;
    logic          vld_p1;
    logic          is_read_p1;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    resp_t         push_data;
    resp_t         head;
    logic [CW-1:0] level;
    logic [CW-1:0] level_nxt;
    logic          head_nxt;
    logic          load_nxt;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_nxt;
    logic          unused_bits;

    // Stage p0: acceptance and RAM access in the handshake cycle
    assign addr_ok   = (out_cnt < CW'(MAX_OUT));
    assign hs        = req & addr_ok;
    assign ram_en    = hs;
    assign ram_we    = (hs & wr) ? wstrb : 4'b0000;
    assign ram_addr  = addr[RAM_AW+1:2];
    assign ram_wdata = wdata;

    // Stage p1: RAM read data is captured into the response queue
    assign push      = vld_p1 & ~fifo_full;
    assign push_data = '{is_read: is_read_p1, data: is_read_p1 ? ram_rdata : 32'h0};
    assign pop       = data_ok;

    resp_fifo #(
        .DEPTH (MAX_OUT)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Stage p2: look one cycle ahead so data_ok can come straight from a flop.
    // Queue occupancy is the outstanding count minus the one still in p1.
    assign level     = out_cnt - CW'(vld_p1);
    assign level_nxt = level + CW'(push) - CW'(pop);
    assign head_nxt  = (level_nxt != '0);
    assign load_nxt  = head_nxt & (pop | fifo_empty);
    assign wait_nxt  = load_nxt ? delay_cfg :
                       (wait_cnt != 4'd0) ? wait_cnt - 4'd1 : 4'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_cnt  <= '0;
            vld_p1   <= 1'b0;
            wait_cnt <= 4'd0;
            data_ok  <= 1'b0;
        end else begin
            unique case ({hs, pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            vld_p1   <= hs;
            wait_cnt <= wait_nxt;
            data_ok  <= head_nxt & (wait_nxt == 4'd0);
        end
    end

    always_ff @(posedge clk) begin
        is_read_p1 <= ~wr;
    end

    assign rdata = (data_ok & head.is_read) ? head.data : 32'h0;

    // Size and byte offset are resolved by the master; they do not steer the RAM.
    assign unused_bits = ^{size_legal(size), addr[1:0], addr[31:RAM_AW+2]};

endmodule

// File: tb/tb_sram_like_slave.sv
// Directed bench for sram_like_slave with a behavioural synchronous RAM.
module tb_sram_like_slave;
    import sram_like_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req;
    logic          wr;
    logic [3:0]    wstrb;
    logic [1:0]    size;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [31:0]   rdata;
    logic [3:0]    delay_cfg;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    logic [31:0]   ram [256];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic [AW-1:0] pre_addr [5];
    logic [31:0]   pre_data [5];
    logic [31:0]   exp_rd;

    int checks = 0;
    int errors = 0;

    sram_like_slave #(
        .RAM_AW  (AW),
        .MAX_OUT (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .wr        (wr),
        .wstrb     (wstrb),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .rdata     (rdata),
        .delay_cfg (delay_cfg),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= ram[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req   = r;
        wr    = w;
        wstrb = s;
        addr  = a;
        wdata = d;
    endtask

    initial begin
        resetn    = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        delay_cfg = 4'd0;
        size      = SZ_WORD;
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        pre_addr[0] = 8'd5; pre_data[0] = 32'hDEADBEEF;
        pre_addr[1] = 8'd8; pre_data[1] = 32'hAAAAAAAA;
        pre_addr[2] = 8'd1; pre_data[2] = 32'h11111111;
        pre_addr[3] = 8'd2; pre_data[3] = 32'h22222222;
        pre_addr[4] = 8'd3; pre_data[4] = 32'h33333333;

        // preload RAM while reset is held
        for (int i = 0; i < 5; i++) begin
            ld_en   = 1'b1;
            ld_addr = pre_addr[i];
            ld_data = pre_data[i];
            step();
        end
        ld_en = 1'b0;
        step();
        #1;
        chk("rst_addr_ok", 32'(addr_ok), 32'd1);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_rdata",   rdata,        32'd0);
        chk("rst_ram_en",  32'(ram_en),  32'd0);
        chk("rst_ram_we",  32'(ram_we),  32'd0);
        resetn = 1'b1;
        step();

        // single read, delay 0
        drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        #1;
        chk("t1_addr_ok",  32'(addr_ok),  32'd1);
        chk("t1_ram_en",   32'(ram_en),   32'd1);
        chk("t1_ram_addr", 32'(ram_addr), 32'd5);
        chk("t1_ram_we",   32'(ram_we),   32'd0);
        step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        chk("t1_dok_t1", 32'(data_ok), 32'd0);
        step(); #1;
        chk("t1_dok_t2", 32'(data_ok), 32'd1);
        chk("t1_rdata",  rdata,        32'hDEADBEEF);
        step(); #1;
        chk("t1_dok_t3",   32'(data_ok), 32'd0);
        chk("t1_rdata_t3", rdata,        32'd0);

        // partial write then read of the same word
        step();
        drive(1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        #1;
        chk("t2_ram_en",    32'(ram_en),   32'd1);
        chk("t2_ram_we",    32'(ram_we),   32'd3);
        chk("t2_ram_wdata", ram_wdata,     32'h12345678);
        chk("t2_ram_addr",  32'(ram_addr), 32'd8);
        step(); drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0); #1;
        chk("t2_addr_ok_2nd", 32'(addr_ok), 32'd1);
        chk("t2_dok_t1",      32'(data_ok), 32'd0);
        step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        chk("t2_wr_dok",   32'(data_ok), 32'd1);
        chk("t2_wr_rdata", rdata,        32'd0);
        step(); #1;
        chk("t2_rd_dok",   32'(data_ok), 32'd1);
        chk("t2_rd_rdata", rdata,        32'hAAAA5678);
        step(); #1;
        chk("t2_dok_idle", 32'(data_ok), 32'd0);

        // backpressure: req held, delay 3, three reads
        delay_cfg = 4'd3;
        step();
        for (int k = 0; k <= 14; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
            else if (k == 1) drive(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
            else if (k <= 6) drive(1'b1, 1'b0, 4'h0, 32'hC, 32'h0);
            else             drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            #1;
            exp_rd = (k == 5) ? 32'h11111111 : (k == 9) ? 32'h22222222 :
                     (k == 13) ? 32'h33333333 : 32'h0;
            chk($sformatf("t3_addr_ok_k%0d", k), 32'(addr_ok), 32'(k <= 1 || k == 6 || k >= 10));
            chk($sformatf("t3_ram_en_k%0d", k),  32'(ram_en),  32'(k <= 1 || k == 6));
            chk($sformatf("t3_dok_k%0d", k),     32'(data_ok), 32'(k == 5 || k == 9 || k == 13));
            chk($sformatf("t3_rdata_k%0d", k),   rdata,        exp_rd);
            step();
        end

        // handshake and data_ok in the same cycle with one outstanding
        delay_cfg = 4'd0;
        size = SZ_BYTE;
        drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        #1;
        chk("t4_ram_en_1", 32'(ram_en), 32'd1);
        step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        step(); drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0); #1;
        chk("t4_addr_ok_sim", 32'(addr_ok), 32'd1);
        chk("t4_dok_sim",     32'(data_ok), 32'd1);
        chk("t4_ram_en_sim",  32'(ram_en),  32'd1);
        chk("t4_rdata_sim",   rdata,        32'hDEADBEEF);
        step(); drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        chk("t4_addr_ok_after", 32'(addr_ok), 32'd1);
        chk("t4_dok_after",     32'(data_ok), 32'd0);
        step(); #1;
        chk("t4_dok_2nd",   32'(data_ok), 32'd1);
        chk("t4_rdata_2nd", rdata,        32'h11111111);
        step();
        size = SZ_WORD;

        // delay change while the head is counting
        delay_cfg = 4'd4;
        for (int k = 0; k <= 9; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
            else if (k == 1) drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
            else             drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            if (k == 3) delay_cfg = 4'd0;
            #1;
            exp_rd = (k == 6) ? 32'hDEADBEEF : (k == 7) ? 32'h11111111 : 32'h0;
            chk($sformatf("t5_dok_k%0d", k),   32'(data_ok), 32'(k == 6 || k == 7));
            chk($sformatf("t5_rdata_k%0d", k), rdata,        exp_rd);
            step();
        end

        // reset with two transactions outstanding
        delay_cfg = 4'd2;
        for (int k = 0; k <= 14; k++) begin
            if (k == 0)       drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
            else if (k == 1)  drive(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
            else if (k == 11) drive(1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
            else              drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            resetn = (k != 2);
            if (k == 3) delay_cfg = 4'd0;
            #1;
            if (k >= 3) begin
                exp_rd = (k == 13) ? 32'hDEADBEEF : 32'h0;
                chk($sformatf("t6_addr_ok_k%0d", k), 32'(addr_ok), 32'd1);
                chk($sformatf("t6_dok_k%0d", k),     32'(data_ok), 32'(k == 13));
                chk($sformatf("t6_rdata_k%0d", k),   rdata,        exp_rd);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
